fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
Multi-cycle controller for the instruction-fetch path. It owns the word-addressed PC and drives a request/acknowledge instruction memory. It holds each fetched instruction until the datapath accepts it, then computes the next PC: sequential, jump, or taken branch. It replaces the free-running single-cycle PC update when instruction memory has wait states and the datapath can stall.

Parameters:
RESET_WORD, 30'h0, word address (bits 31:2) loaded into the PC on reset
TIMEOUT, 16, max request cycles without imem_ack before fault; 0 disables the timeout
CNT_W, 32, width of the retired-instruction counter

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
imem_req  output  1  instruction memory read request
imem_addr  output  30  word address [31:2] of the request; equals the current PC
imem_ack  input  1  memory has valid imem_rdata this cycle
imem_rdata  input  32  instruction word from memory
inst_valid  output  1  instruction/inst_pc hold a fetched instruction
instruction  output  32  latched instruction word
inst_pc  output  30  word address of the latched instruction
inst_ready  input  1  datapath consumes instruction this cycle
jump  input  1  control: current instruction is J-type jump
branch  input  1  control: current instruction is a conditional branch
zero  input  1  ALU zero flag for the current instruction
fetch_err  output  1  sticky memory timeout fault
inst_count  output  CNT_W  number of accepted instructions

Behaviour:
- Clock is clk; reset is synchronous and active-high. All regs update only on the rising clk edge.
- Reset values: state=FETCH, pc=RESET_WORD, instruction=0, inst_pc=0, inst_valid=0, fetch_err=0, inst_count=0, timeout counter=0.
- imem_req=1 during the first cycle after reset deasserts.
- Reset asserted in any state, including mid-request or in ERR, overrides everything on that edge.
- States:
  - FETCH: imem_req=1; imem_addr=pc, stable until ack. On imem_ack: instruction<=imem_rdata, inst_pc<=pc, go to HOLD, clear the timeout counter. Without ack, increment the timeout counter.
  - HOLD: imem_req=0, inst_valid=1, instruction and inst_pc stable. While inst_ready=0, stay in HOLD. When inst_ready=1 (the accept cycle): sample jump/branch/zero, load pc<=next_pc, increment inst_count, go to FETCH.
  - ERR: imem_req=0, inst_valid=0, fetch_err=1. Leaves only via reset.
- Timeout rule: if TIMEOUT!=0 and a FETCH cycle has no ack while the counter equals TIMEOUT-1, go to ERR on that edge. An ack on that same cycle wins, and the FSM goes to HOLD.
- imem_rdata and imem_ack are ignored outside FETCH.
- Latency:
  - Ack in cycle N gives inst_valid=1 in cycle N+1.
  - Accept in cycle M gives imem_req=1 with the new address in cycle M+1.
  - Zero-wait memory (ack in the first request cycle) sustains 1 instruction per 2 cycles.
- next_pc, computed from inst_pc and instruction (30-bit, modulo 2^30):
  - jump=1: {inst_pc[29:26], instruction[25:0]}. Jump has priority over branch.
  - branch=1 and zero=1: inst_pc + 1 + sign_extend30(instruction[15:0]).
  - Otherwise: inst_pc + 1.
  - Wrap-around: 30'h3FFFFFFF + 1 = 0, with no flag.
- jump, branch and zero matter only on the accept cycle; they are don't-care elsewhere.
- inst_count wraps at 2^CNT_W silently and does not increment in ERR.

Test Plan:
- Reset: hold reset 3 cycles with RESET_WORD=30'h0C00 → imem_req=0, inst_valid=0, fetch_err=0, inst_count=0 during reset. Cycle after release: imem_req=1, imem_addr=30'h0C00.
- Sequential zero-wait: ack every request with rdata=addr-derived word, inst_ready=1 → imem_addr sequence 0C00, 0C01, 0C02 on every other cycle; inst_count=3 after the third accept.
- Backpressure/wait states: ack after 3 cycles, then inst_ready low 4 cycles → imem_addr stable for all 3 request cycles; instruction and inst_pc stable while inst_valid=1; no new imem_req until the cycle after inst_ready=1.
- Branch/jump:
  - inst_pc=30'h0C05, instruction[15:0]=16'hFFFD, branch=1, zero=1 → next imem_addr=30'h0C03.
  - Same with zero=0 → 30'h0C06.
  - inst_pc=30'h0C05, instruction[25:0]=26'h0000100, jump=1, branch=1 → 30'h0000100.
- Timeout: TIMEOUT=16, never ack → imem_req high exactly 16 cycles, then fetch_err=1, imem_req=0. Apply reset → returns to FETCH at RESET_WORD with fetch_err=0.
- Reset mid-operation and wrap: assert reset during FETCH wait and during HOLD → next cycle FETCH at RESET_WORD, inst_valid=0. Sequential accept at inst_pc=30'h3FFFFFFF → next imem_addr=0.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, handshakes with a wait-state
// instruction memory and holds each fetched word until the datapath takes it.
module fetch_sequencer #(
    parameter logic [29:0] RESET_WORD = 30'h0,
    parameter int unsigned TIMEOUT    = 16,
    parameter int unsigned CNT_W      = 32
) (
    input  logic             clk,
    input  logic             reset,
    output logic             imem_req,
    output logic [29:0]      imem_addr,
    input  logic             imem_ack,
    input  logic [31:0]      imem_rdata,
    output logic             inst_valid,
    output logic [31:0]      instruction,
    output logic [29:0]      inst_pc,
    input  logic             inst_ready,
    input  logic             jump,
    input  logic             branch,
    input  logic             zero,
    output logic             fetch_err,
    output logic [CNT_W-1:0] inst_count
);

    typedef enum logic [1:0] {
        FETCH,
        HOLD,
        ERR
    } state_t;

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam bit TMO_EN = (TIMEOUT != 0);
    localparam logic [TW-1:0] TMO_LAST =
        (TIMEOUT == 0) ? '0 : TW'(TIMEOUT - 1);

    state_t      state;
    logic [29:0] pc;
    logic [TW-1:0] tmo_cnt;
    logic [29:0] next_pc;
    logic [29:0] br_off;

    assign br_off = {{14{instruction[15]}}, instruction[15:0]};

    always_comb begin
        next_pc = inst_pc + 30'd1;
        priority case (1'b1)
            jump:            next_pc = {inst_pc[29:26], instruction[25:0]};
            branch && zero:  next_pc = inst_pc + 30'd1 + br_off;
            default:         next_pc = inst_pc + 30'd1;
        endcase
    end

    // Request is masked while reset is held so memory never sees a stale fetch.
    assign imem_req   = (state == FETCH) && !reset;
    assign imem_addr  = pc;
    assign inst_valid = (state == HOLD);
    assign fetch_err  = (state == ERR);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= FETCH;
            pc          <= RESET_WORD;
            instruction <= '0;
            inst_pc     <= '0;
            inst_count  <= '0;
            tmo_cnt     <= '0;
        end else begin
            case (state)
                FETCH: begin
                    if (imem_ack) begin
                        instruction <= imem_rdata;
                        inst_pc     <= pc;
                        tmo_cnt     <= '0;
                        state       <= HOLD;
                    end else if (TMO_EN && tmo_cnt == TMO_LAST) begin
                        state <= ERR;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (inst_ready) begin
                        pc         <= next_pc;
                        inst_count <= inst_count + 1'b1;
                        state      <= FETCH;
                    end
                end
                ERR: begin
                    state <= ERR;
                end
                default: begin
                    state <= FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: a memory/datapath driver feeds a
// PC reference model, a separate monitor pops expectations and compares.
module tb_fetch_sequencer;

    localparam logic [29:0] RW = 30'h0C00;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [29:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        inst_valid;
    logic [31:0] instruction;
    logic [29:0] inst_pc;
    logic        inst_ready = 1'b0;
    logic        jump = 1'b0;
    logic        branch = 1'b0;
    logic        zero = 1'b0;
    logic        fetch_err;
    logic [31:0] inst_count;

    always #5 clk = ~clk;

    fetch_sequencer #(
        .RESET_WORD(RW),
        .TIMEOUT(16),
        .CNT_W(32)
    ) dut (
        .clk(clk),
        .reset(reset),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_ack(imem_ack),
        .imem_rdata(imem_rdata),
        .inst_valid(inst_valid),
        .instruction(instruction),
        .inst_pc(inst_pc),
        .inst_ready(inst_ready),
        .jump(jump),
        .branch(branch),
        .zero(zero),
        .fetch_err(fetch_err),
        .inst_count(inst_count)
    );

    typedef struct {
        logic [31:0] ins;
        logic [29:0] pc;
    } exp_t;

    int errors = 0;
    int checks = 0;

    logic [29:0] addr_q[$];
    exp_t        exp_q[$];
    logic [31:0] rd_q[$];
    logic [2:0]  ctl_q[$];
    logic [29:0] addr_log[$];

    int wait_cfg = 0;
    int ready_cfg = 0;
    bit no_ack = 0;
    bit err_ok = 0;
    int rst_cnt = 3;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Next fetch address from the architectural rules, in plain arithmetic.
    function automatic logic [29:0] ref_next(input logic [29:0] pc,
                                             input logic [31:0] ins,
                                             input bit j, input bit b,
                                             input bit z);
        longint m;
        longint p;
        longint r;
        m = longint'(1) << 30;
        p = longint'(pc);
        if (j)
            r = (p / (longint'(1) << 26)) * (longint'(1) << 26)
                + (longint'(ins) % (longint'(1) << 26));
        else if (b && z)
            r = p + 1 + longint'(shortint'(ins[15:0]));
        else
            r = p + 1;
        r = ((r % m) + m) % m;
        return r[29:0];
    endfunction

    function automatic logic [2:0] rand_ctl();
        logic [2:0] c;
        c[2] = ($urandom_range(0, 7) == 0);
        c[1] = ($urandom_range(0, 3) == 0);
        c[0] = 1'($urandom);
        return c;
    endfunction

    function automatic int pick_wait();
        if (wait_cfg >= 0) return wait_cfg;
        if ($urandom_range(0, 7) == 0) return 15;
        return $urandom_range(0, 3);
    endfunction

    // Driver: memory with wait states, datapath with backpressure, model PC.
    initial begin
        logic [29:0] model_pc;
        logic [31:0] cur_ins;
        logic [2:0]  c;
        bit in_req;
        bit in_hold;
        int wait_left;
        int hold_left;
        model_pc = RW;
        cur_ins = '0;
        in_req = 0;
        in_hold = 0;
        wait_left = 0;
        hold_left = 0;
        forever begin
            @(posedge clk);
            #1;
            if (rst_cnt > 0) begin
                reset = 1'b1;
                rst_cnt--;
                imem_ack = 1'b0;
                inst_ready = 1'b0;
                imem_rdata = $urandom;
                addr_q.delete();
                addr_q.push_back(RW);
                exp_q.delete();
                model_pc = RW;
                in_req = 0;
                in_hold = 0;
            end else begin
                reset = 1'b0;
                #1;
                if (imem_req) begin
                    if (!in_req) begin
                        in_req = 1;
                        wait_left = pick_wait();
                    end
                    if (!no_ack && wait_left == 0) begin
                        imem_ack = 1'b1;
                        imem_rdata = (rd_q.size() != 0) ? rd_q.pop_front()
                                                        : $urandom;
                        exp_q.push_back('{imem_rdata, model_pc});
                        cur_ins = imem_rdata;
                        in_req = 0;
                    end else begin
                        imem_ack = 1'b0;
                        imem_rdata = $urandom;
                        if (wait_left > 0) wait_left--;
                    end
                end else begin
                    in_req = 0;
                    imem_ack = 1'($urandom);
                    imem_rdata = $urandom;
                end
                if (inst_valid) begin
                    if (!in_hold) begin
                        in_hold = 1;
                        hold_left = (ready_cfg < 0) ? $urandom_range(0, 3)
                                                    : ready_cfg;
                    end
                    if (hold_left == 0) begin
                        inst_ready = 1'b1;
                        c = (ctl_q.size() != 0) ? ctl_q.pop_front()
                                                : rand_ctl();
                        {jump, branch, zero} = c;
                        model_pc = ref_next(model_pc, cur_ins,
                                            c[2], c[1], c[0]);
                        addr_q.push_back(model_pc);
                        in_hold = 0;
                    end else begin
                        inst_ready = 1'b0;
                        {jump, branch, zero} = 3'($urandom);
                        hold_left--;
                    end
                end else begin
                    in_hold = 0;
                    inst_ready = 1'($urandom);
                    {jump, branch, zero} = 3'($urandom);
                end
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents a request or word.
    initial begin
        bit rst_seen;
        bit prev_req;
        bit prev_ackd;
        bit prev_valid;
        bit prev_acc;
        bit first;
        logic [29:0] h_addr;
        logic [29:0] h_pc;
        logic [31:0] h_ins;
        logic [31:0] acc_seen;
        exp_t e;
        rst_seen = 0;
        prev_req = 0;
        prev_ackd = 0;
        prev_valid = 0;
        prev_acc = 0;
        h_addr = '0;
        h_pc = '0;
        h_ins = '0;
        acc_seen = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                chk("rst_req", 64'(imem_req), 64'(0));
                if (rst_seen) begin
                    chk("rst_valid", 64'(inst_valid), 64'(0));
                    chk("rst_err", 64'(fetch_err), 64'(0));
                    chk("rst_count", 64'(inst_count), 64'(0));
                end
                rst_seen = 1;
                prev_req = 0;
                prev_ackd = 0;
                prev_valid = 0;
                prev_acc = 0;
                acc_seen = '0;
                addr_log.delete();
            end else begin
                first = rst_seen;
                rst_seen = 0;
                if (imem_req) begin
                    if (!prev_req) begin
                        chk("req_after_accept", 64'(first || prev_acc), 64'(1));
                        if (addr_q.size() == 0) begin
                            chk("addr_q_empty", 64'(0), 64'(1));
                        end else begin
                            chk("imem_addr", 64'(imem_addr),
                                64'(addr_q.pop_front()));
                        end
                        addr_log.push_back(imem_addr);
                        h_addr = imem_addr;
                    end else begin
                        chk("addr_stable", 64'(imem_addr), 64'(h_addr));
                    end
                end
                if (prev_ackd)
                    chk("valid_latency", 64'(inst_valid), 64'(1));
                if (prev_acc)
                    chk("req_latency", 64'(imem_req), 64'(1));
                if (inst_valid) begin
                    if (!prev_valid) begin
                        chk("valid_cause", 64'(prev_ackd), 64'(1));
                        if (exp_q.size() == 0) begin
                            chk("exp_q_empty", 64'(0), 64'(1));
                        end else begin
                            e = exp_q.pop_front();
                            chk("instruction", 64'(instruction), 64'(e.ins));
                            chk("inst_pc", 64'(inst_pc), 64'(e.pc));
                        end
                        h_ins = instruction;
                        h_pc = inst_pc;
                    end else begin
                        chk("ins_stable", 64'(instruction), 64'(h_ins));
                        chk("pc_stable", 64'(inst_pc), 64'(h_pc));
                    end
                end
                chk("req_xor_valid", 64'(imem_req && inst_valid), 64'(0));
                if (!err_ok)
                    chk("no_fault", 64'(fetch_err), 64'(0));
                chk("inst_count", 64'(inst_count), 64'(acc_seen));
                prev_req = imem_req;
                prev_ackd = imem_req && imem_ack;
                prev_valid = inst_valid;
                prev_acc = inst_valid && inst_ready;
                if (prev_acc) acc_seen = acc_seen + 1;
            end
        end
    end

    task automatic do_reset(input int n);
        rst_cnt = n;
        do @(negedge clk); while (rst_cnt != 0 || reset);
    endtask

    task automatic chk_restart(input string name);
        chk({name, "_req"}, 64'(imem_req), 64'(1));
        chk({name, "_addr"}, 64'(imem_addr), 64'(RW));
        chk({name, "_valid"}, 64'(inst_valid), 64'(0));
    endtask

    initial begin
        logic [29:0] dir_exp[14];
        logic [2:0]  dir_ctl[13];
        logic [31:0] dir_rd[13];
        int n;

        // Zero-wait sequential fetch straight out of reset.
        wait_cfg = 0;
        ready_cfg = 0;
        ctl_q = '{3'b000, 3'b000, 3'b000};
        do @(negedge clk); while (rst_cnt != 0 || reset);
        chk_restart("post_reset");
        repeat (6) @(negedge clk);
        chk("zero_wait_count", 64'(inst_count), 64'(3));
        chk("seq_addr0", 64'(addr_log[0]), 64'(30'h0C00));
        chk("seq_addr1", 64'(addr_log[1]), 64'(30'h0C01));
        chk("seq_addr2", 64'(addr_log[2]), 64'(30'h0C02));

        // Wait states plus datapath backpressure.
        wait_cfg = 2;
        ready_cfg = 4;
        repeat (40) @(negedge clk);

        // Directed branch / jump / wrap sequence.
        dir_ctl = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b011,
                    3'b000, 3'b000, 3'b010, 3'b111, 3'b011, 3'b000, 3'b000};
        dir_rd = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h1234FFFD,
                   32'h0, 32'h0, 32'hABCDFFFD, 32'hFC000100, 32'h0000FEFE,
                   32'h0, 32'h0};
        dir_exp = '{30'h0C00, 30'h0C01, 30'h0C02, 30'h0C03, 30'h0C04,
                    30'h0C05, 30'h0C03, 30'h0C04, 30'h0C05, 30'h0C06,
                    30'h0000100, 30'h3FFFFFFF, 30'h0, 30'h1};
        rd_q.delete();
        ctl_q.delete();
        for (int i = 0; i < 13; i++) begin
            ctl_q.push_back(dir_ctl[i]);
            rd_q.push_back(dir_rd[i] == 32'h0 ? {$urandom} : dir_rd[i]);
        end
        wait_cfg = 0;
        ready_cfg = 0;
        do_reset(2);
        for (int i = 0; i < 200 && ctl_q.size() != 0; i++)
            @(negedge clk);
        chk("dir_done", 64'(ctl_q.size()), 64'(0));
        repeat (3) @(negedge clk);
        chk("dir_log_len", 64'(addr_log.size() >= 14), 64'(1));
        for (int i = 0; i < 14 && i < addr_log.size(); i++)
            chk($sformatf("dir_addr%0d", i), 64'(addr_log[i]),
                64'(dir_exp[i]));

        // Reset landing in a FETCH wait and in HOLD.
        wait_cfg = 8;
        do_reset(1);
        repeat (3) @(negedge clk);
        chk("mid_fetch_waiting", 64'(imem_req), 64'(1));
        do_reset(1);
        chk_restart("rst_in_fetch");
        wait_cfg = 0;
        ready_cfg = 10;
        do_reset(1);
        repeat (2) @(negedge clk);
        chk("mid_hold_holding", 64'(inst_valid), 64'(1));
        do_reset(1);
        chk_restart("rst_in_hold");

        // Ack on the last allowed request cycle must not fault.
        wait_cfg = 15;
        ready_cfg = 0;
        ctl_q = '{3'b000, 3'b000, 3'b000, 3'b000};
        do_reset(1);
        repeat (80) @(negedge clk);
        chk("late_ack_count", 64'(inst_count), 64'(4));
        chk("late_ack_no_err", 64'(fetch_err), 64'(0));

        // Random traffic with periodic resets.
        wait_cfg = -1;
        ready_cfg = -1;
        for (int k = 0; k < 6; k++) begin
            repeat (500) @(negedge clk);
            do_reset($urandom_range(1, 3));
            chk_restart("rand_reset");
        end
        repeat (300) @(negedge clk);

        // Memory that never answers.
        err_ok = 1;
        no_ack = 1;
        do_reset(2);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (imem_req) n++;
            @(negedge clk);
        end
        chk("timeout_req_cycles", 64'(n), 64'(16));
        chk("timeout_err", 64'(fetch_err), 64'(1));
        chk("timeout_req_off", 64'(imem_req), 64'(0));
        chk("timeout_valid_off", 64'(inst_valid), 64'(0));
        chk("timeout_count", 64'(inst_count), 64'(0));
        do_reset(2);
        no_ack = 0;
        err_ok = 0;
        chk("recover_err", 64'(fetch_err), 64'(0));
        chk_restart("recover");
        repeat (60) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
